core8_cpu_1_oci_dct_packer: RTL and testbench

Transmit-side packer for the per-core OCI direct-control-transfer (DCT) trace path. It collects 2-bit DCT atoms from the CPU trace port and packs up to 15 of them into a 30-bit word with a 4-bit atom count. Each word is presented on the `dct_buffer`/`dct_count` interface consumed by the OCI trace sink and test-bench monitor. It also drives the end-of-test handshake (`test_ending`, `test_has_ended`) once all buffered trace has drained.

---
 rtl/core8_oci_pkg.sv | 19 +
 rtl/core8_oci_dct_slot.sv | 39 +++
 rtl/core8_cpu_1_oci_dct_packer.sv | 86 ++++++++
 tb/tb_core8_cpu_1_oci_dct_packer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/core8_oci_pkg.sv
// core8_oci_pkg: shared widths, atom codes and FSM states for the OCI DCT trace packer
package core8_oci_pkg;
  localparam int DCT_ATOM_W = 2;
  localparam int DCT_DEPTH = 15;
  localparam int DCT_BUF_W = DCT_ATOM_W * DCT_DEPTH;
  localparam int DCT_CNT_W = 4;
  localparam int DCT_IDLE_CYCLES = 64;
  typedef enum logic [DCT_ATOM_W-1:0] {
    ATOM_NT  = 2'b00,
    ATOM_TK  = 2'b01,
    ATOM_EXC = 2'b10,
    ATOM_IND = 2'b11
  } atom_e;
  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_ENDED
  } state_e;
endpackage

// File: rtl/core8_oci_dct_slot.sv
// core8_oci_dct_slot: one-entry valid/ready output register holding a packed DCT word and its count
module core8_oci_dct_slot
  import core8_oci_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DCT_BUF_W-1:0] load_buf,
  input  logic [DCT_CNT_W-1:0] load_cnt,
  input  logic                 ready,
  output logic                 free,
  output logic                 valid,
  output logic [DCT_BUF_W-1:0] buffer,
  output logic [DCT_CNT_W-1:0] count
);
  logic                 valid_d, valid_q;
  logic [DCT_BUF_W-1:0] buf_d, buf_q;
  logic [DCT_CNT_W-1:0] cnt_d, cnt_q;
  always_comb begin
    valid_d = load | (valid_q & ~ready);
    buf_d = load ? load_buf : buf_q;
    cnt_d = load ? load_cnt : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end
  assign free = ~valid_q | ready;
  assign valid = valid_q;
  assign buffer = buf_q;
  assign count = cnt_q;
endmodule

// File: rtl/core8_cpu_1_oci_dct_packer.sv
// core8_cpu_1_oci_dct_packer: packs 2-bit DCT atoms into 15-atom words with end-of-test drain; CORE8_DCT_IDLE_FLUSH_EN adds an idle-timeout flush
module core8_cpu_1_oci_dct_packer
  import core8_oci_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  atom_valid,
  input  logic [DCT_ATOM_W-1:0] atom,
  input  logic                  flush,
  input  logic                  end_req,
  input  logic                  dct_ready,
  output logic [DCT_BUF_W-1:0]  dct_buffer,
  output logic [DCT_CNT_W-1:0]  dct_count,
  output logic                  dct_valid,
  output logic                  overflow,
  output logic                  test_ending,
  output logic                  test_has_ended
);
  state_e               state_q, state_d;
  logic [DCT_BUF_W-1:0] acc_q, acc_d, acc_base;
  logic [DCT_CNT_W-1:0] acc_cnt_q, acc_cnt_d, cnt_base;
  logic                 flush_pend_q, flush_pend_d;
  logic                 overflow_q, overflow_d;
  logic                 ending_q, ending_d, ended_q, ended_d;
  logic                 slot_free, run, full, flush_eff, xfer, accept, idle_hit;
`ifdef CORE8_DCT_IDLE_FLUSH_EN
  localparam int IDLE_W = $clog2(DCT_IDLE_CYCLES + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  assign idle_hit = idle_q == IDLE_W'(DCT_IDLE_CYCLES);
  always_comb idle_d = (atom_valid || idle_hit || acc_cnt_q == '0) ? '0 : idle_q + IDLE_W'(1);
  always_ff @(posedge clk) idle_q <= reset ? '0 : idle_d;
`else
  assign idle_hit = 1'b0;
`endif
  always_comb begin
    run = state_q == ST_RUN;
    full = acc_cnt_q == DCT_CNT_W'(DCT_DEPTH);
    flush_eff = flush_pend_q | flush | idle_hit;
    xfer = slot_free & (full | ((flush_eff | state_q == ST_DRAIN) & acc_cnt_q != '0));
    accept = run & atom_valid & (~full | xfer);
    acc_base = xfer ? '0 : acc_q;
    cnt_base = xfer ? '0 : acc_cnt_q;
    acc_d = accept ? {acc_base[DCT_BUF_W-DCT_ATOM_W-1:0], atom} : acc_base;
    acc_cnt_d = cnt_base + DCT_CNT_W'(accept);
    flush_pend_d = ~xfer & (acc_cnt_q != '0) & flush_eff;
    overflow_d = overflow_q | (run & atom_valid & full & ~slot_free);
    state_d = (run && end_req) ? ST_DRAIN :
              (state_q == ST_DRAIN && acc_cnt_q == '0 && !dct_valid) ? ST_ENDED : state_q;
    ending_d = state_q != ST_RUN;
    ended_d = state_q == ST_ENDED;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      acc_q <= '0;
      acc_cnt_q <= '0;
      flush_pend_q <= 1'b0;
      overflow_q <= 1'b0;
      ending_q <= 1'b0;
      ended_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      flush_pend_q <= flush_pend_d;
      overflow_q <= overflow_d;
      ending_q <= ending_d;
      ended_q <= ended_d;
    end
  end
  core8_oci_dct_slot u_slot (
    .clk      (clk),
    .reset    (reset),
    .load     (xfer),
    .load_buf (acc_q),
    .load_cnt (acc_cnt_q),
    .ready    (dct_ready),
    .free     (slot_free),
    .valid    (dct_valid),
    .buffer   (dct_buffer),
    .count    (dct_count)
  );
  assign overflow = overflow_q;
  assign test_ending = ending_q;
  assign test_has_ended = ended_q;
endmodule

// File: tb/tb_core8_cpu_1_oci_dct_packer.sv
// tb_core8_cpu_1_oci_dct_packer: directed and randomized checks against a queue-based packer model
module tb_core8_cpu_1_oci_dct_packer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom = 2'b00;
  logic        flush = 1'b0;
  logic        end_req = 1'b0;
  logic        dct_ready = 1'b1;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid, overflow, test_ending, test_has_ended;
  int total = 0;
  int bad = 0;
  int hs = 0;
  bit started = 1'b0;
  int q[$];
  bit m_valid, m_fp, m_ovf, m_end, m_ended;
  int m_buf, m_cnt, m_state, m_idle;

  core8_cpu_1_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .atom_valid     (atom_valid),
    .atom           (atom),
    .flush          (flush),
    .end_req        (end_req),
    .dct_ready      (dct_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .dct_valid      (dct_valid),
    .overflow       (overflow),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pack_q();
    int w = 0;
    foreach (q[i]) w = w * 4 + q[i];
    return w;
  endfunction

  always @(posedge clk) begin : model
    int n, st;
    bit free, fl, go, hit;
    started = 1'b1;
    if (!reset && dct_valid && dct_ready) hs++;
    if (reset) begin
      q.delete();
      m_valid = 0; m_buf = 0; m_cnt = 0; m_fp = 0; m_ovf = 0;
      m_state = 0; m_end = 0; m_ended = 0; m_idle = 0;
    end else begin
      n = q.size();
      st = m_state;
      free = !m_valid || dct_ready;
      hit = 1'b0;
`ifdef CORE8_DCT_IDLE_FLUSH_EN
      hit = m_idle == 64;
      m_idle = (atom_valid || hit || n == 0) ? 0 : m_idle + 1;
`endif
      fl = m_fp || flush || hit;
      go = free && (n == 15 || (n != 0 && (fl || st == 1)));
      m_end = st != 0;
      m_ended = st == 2;
      if (st == 0 && end_req) m_state = 1;
      else if (st == 1 && n == 0 && !m_valid) m_state = 2;
      if (go) begin
        m_buf = pack_q();
        m_cnt = n;
        m_valid = 1'b1;
        q.delete();
      end else if (m_valid && dct_ready) m_valid = 1'b0;
      if (st == 0 && atom_valid) begin
        if (q.size() < 15) q.push_back(int'(atom));
        else m_ovf = 1'b1;
      end
      m_fp = !go && n != 0 && fl;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cyc_valid", dct_valid, m_valid);
      check("cyc_count", dct_count, m_cnt);
      check("cyc_buffer", dct_buffer, m_buf);
      check("cyc_overflow", overflow, m_ovf);
      check("cyc_ending", test_ending, m_end);
      check("cyc_ended", test_has_ended, m_ended);
    end
  end

  task automatic step(bit av, bit [1:0] a, bit fl, bit er, bit rdy);
    atom_valid = av;
    atom = a;
    flush = fl;
    end_req = er;
    dct_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int h0, seen, cseen, wait_n;
    repeat (2) step(0, 0, 0, 0, 1);
    reset = 1'b0;
    check("rst_valid", dct_valid, 0);
    check("rst_buffer", dct_buffer, 0);
    check("rst_count", dct_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ending", test_ending, 0);
    check("rst_ended", test_has_ended, 0);

    for (int i = 0; i < 15; i++) step(1, 2'b01, 0, 0, 1);
    check("full_not_yet", dct_valid, 0);
    step(0, 0, 0, 0, 1);
    check("full_valid", dct_valid, 1);
    check("full_buffer", dct_buffer, 30'h15555555);
    check("full_count", dct_count, 15);
    check("full_ovf", overflow, 0);
    step(0, 0, 0, 0, 1);

    step(1, 2'b10, 0, 0, 1);
    step(1, 2'b01, 0, 0, 1);
    step(1, 2'b11, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    check("flush_valid", dct_valid, 1);
    check("flush_buffer", dct_buffer, 30'h27);
    check("flush_count", dct_count, 3);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    check("flush_empty", dct_valid, 0);

    for (int i = 0; i < 31; i++) step(1, 2'($urandom), 0, 0, 0);
    check("ovf_valid", dct_valid, 1);
    check("ovf_count", dct_count, 15);
    check("ovf_set", overflow, 1);
    h0 = hs;
    repeat (3) step(0, 0, 0, 0, 1);
    check("ovf_words", hs - h0, 2);
    check("ovf_sticky", overflow, 1);
    check("ovf_drained", dct_valid, 0);

    reset = 1'b1;
    step(0, 0, 0, 0, 1);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step(1, 2'($urandom), 0, 0, 1);
    h0 = hs;
    step(0, 0, 0, 1, 1);
    check("end_ending_early", test_ending, 0);
    step(1, 2'($urandom), 0, 0, 1);
    check("end_ending", test_ending, 1);
    check("end_valid", dct_valid, 1);
    check("end_count", dct_count, 5);
    step(1, 2'($urandom), 0, 0, 1);
    step(1, 2'($urandom), 0, 0, 1);
    wait_n = 0;
    while (!test_has_ended && wait_n < 10) begin
      step(0, 0, 0, 0, 1);
      wait_n++;
    end
    check("end_has_ended", test_has_ended, 1);
    check("end_words", hs - h0, 1);
    check("end_ovf", overflow, 0);

    reset = 1'b1;
    step(0, 0, 0, 0, 1);
    reset = 1'b0;
    for (int i = 0; i < 22; i++) step(1, 2'($urandom), 0, 0, 0);
    check("mid_valid", dct_valid, 1);
    reset = 1'b1;
    step(0, 0, 0, 0, 1);
    reset = 1'b0;
    check("mid_rst_valid", dct_valid, 0);
    check("mid_rst_buffer", dct_buffer, 0);
    check("mid_rst_count", dct_count, 0);
    h0 = hs;
    repeat (5) step(0, 0, 0, 0, 1);
    check("mid_no_word", hs - h0, 0);

    step(1, 2'b11, 0, 0, 1);
    step(1, 2'b10, 0, 0, 1);
    seen = 0;
    cseen = 0;
    for (int i = 0; i < 70; i++) begin
      step(0, 0, 0, 0, 1);
      if (dct_valid) begin
        seen++;
        cseen = int'(dct_count);
      end
    end
`ifdef CORE8_DCT_IDLE_FLUSH_EN
    check("idle_words", seen, 1);
    check("idle_count", cseen, 2);
`else
    check("idle_words", seen, 0);
    check("idle_count", cseen, 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      reset = (i == 0) || ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 9) < 7, 2'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 249) == 0, $urandom_range(0, 9) < 6);
    end
    reset = 1'b0;
    step(0, 0, 0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
